layer_mem_arbiter: RTL
======================

Name: layer_mem_arbiter

Overview:
- Arbitrates the single layer-memory port (csel / cwr / crd bus to the L0/L1/L2 result memories) between NREQ engines: conv, maxpool and flatten.
- Issues at most one read or write per cycle.
- Steers read data back to the issuing requester after a fixed memory latency.
- Sits between the engines and the testbench/SRAM layer-memory interface.

Parameters:
- NREQ, 3, number of requesters; index 0 = conv, 1 = pool, 2 = flatten.
- RD_LAT, 1, cycles from the crd-high cycle to the cycle in which cdata_rd is valid; legal range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- req  in  NREQ  per-requester access request; level signal
- we  in  NREQ  1 = write, 0 = read
- lock  in  NREQ  keep the grant for the next access (burst)
- sel  in  3*NREQ  target memory select, requester i at [3i+2:3i]
- addr  in  12*NREQ  word address, requester i at [12i+11:12i]
- wdata  in  20*NREQ  write data, requester i at [20i+19:20i]
- gnt  out  NREQ  one-hot grant, combinational
- rvalid  out  NREQ  one-hot read-data-valid
- rdata  out  20  read data, shared; equals cdata_rd
- busy  out  1  any req pending or any read outstanding
- err  out  1  sticky flag: a request was granted with sel == 0
- cwr  out  1  memory write strobe, registered
- caddr_wr  out  12  memory write address, registered
- cdata_wr  out  20  memory write data, registered
- crd  out  1  memory read strobe, registered
- caddr_rd  out  12  memory read address, registered
- cdata_rd  in  20  memory read data
- csel  out  3  memory select, registered

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous, active-high.
- Reset values: cwr = crd = 0, csel = 0, caddr_wr = caddr_rd = 0, cdata_wr = 0, rr pointer = 0, lock owner cleared, read pipeline cleared, err = 0.
- Handshake:
  - A requester holds req, we, sel, addr and wdata stable until it samples gnt high at a rising edge.
  - The transfer completes at that edge.
  - Holding req high after a grant is a new request for the next cycle.
- Grant selection, in the same cycle:
  - If a lock owner is recorded and that requester has req high, it wins.
  - Otherwise round-robin: the first requester with req high, searching from the rr pointer upward with wrap.
  - No req high: gnt = 0.
- Pointer and lock update at the grant edge:
  - The rr pointer moves to winner+1 mod NREQ.
  - The lock owner becomes the winner if its lock is high; otherwise it is cleared.
  - If the lock owner drops req, the lock is cleared and round-robin resumes that same cycle.
- Issue, in the cycle after the grant edge:
  - Write: cwr = 1, crd = 0, csel = sel, caddr_wr = addr, cdata_wr = wdata.
  - Read: crd = 1, cwr = 0, csel = sel, caddr_rd = addr.
  - cwr and crd are never high together.
- Idle cycle (no grant):
  - cwr = crd = 0 and csel = 0.
  - Address and data registers hold their last values.
- Read return:
  - The winner ID and a valid bit enter an RD_LAT-deep shift pipeline.
  - rvalid[id] is high exactly in the cycle RD_LAT cycles after the crd-high cycle; rdata = cdata_rd.
  - Back-to-back reads from different requesters return in issue order, one per cycle.
  - Total read latency from the grant edge is 1 + RD_LAT cycles.
- Writes and reads may interleave freely. There is no read-after-write hazard check; memory ordering follows issue order.
- busy = |req OR any valid entry in the read pipeline.
- sel == 0 with a grant: the grant still completes and err is set (sticky until reset). The bus stays idle (cwr = crd = 0) for that slot and no rvalid is produced.
- Reset mid-operation: outstanding reads are discarded, no rvalid is asserted afterwards, and the lock and pointer are cleared.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins (conv > pool > flatten). The rr pointer is not implemented; lock still overrides.
- Undefined: round-robin as described above.

Test Plan:
- Single write: req[0] = 1, we = 1, sel = 3'b001, addr = 12'h005, wdata = 20'h12345 → gnt = 3'b001 that cycle; next cycle cwr = 1, csel = 001, caddr_wr = 005, cdata_wr = 12345; the cycle after, cwr = 0 and csel = 0.
- Read latency, RD_LAT = 1: req[1] read, sel = 3'b011, addr = 12'h010; memory returns 20'hABCDE → crd = 1 one cycle after the grant; rvalid = 3'b010 with rdata = ABCDE in the following cycle; rvalid low otherwise.
- Round-robin: req = 3'b111 held, all writes, for 6 cycles → grant order 0, 1, 2, 0, 1, 2. With ARB_FIXED_PRIO_EN defined → 0, 0, 0, ...
- Lock burst: req[2] read with lock = 1, then a write, while req[0] is also high → requester 2 is granted twice in a row; requester 0 is granted once lock[2] drops.
- Interleaved reads: requester 0 reads A while requester 1 reads B in consecutive cycles → rvalid = 001 then 010 in consecutive cycles with the matching data; busy falls to 0 in the cycle after the last rvalid.
- Reset during read plus error: assert reset in the crd-high cycle → no rvalid afterwards and all outputs reset. Separately, sel = 0 request → gnt pulses, cwr = crd = 0, err = 1 and stays 1.

Source files
------------

// File: rtl/layer_mem_arbiter.sv
// Layer-memory port arbiter: grants one of NREQ engines per cycle, drives the registered
// csel/cwr/crd bus and steers read data back. Define ARB_FIXED_PRIO_EN for fixed priority.
module layer_mem_arbiter #(
    parameter int NREQ   = 3,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ-1:0]    lock,
    input  logic [3*NREQ-1:0]  sel,
    input  logic [12*NREQ-1:0] addr,
    input  logic [20*NREQ-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [19:0]        rdata,
    output logic               busy,
    output logic               err,
    output logic               cwr,
    output logic [11:0]        caddr_wr,
    output logic [19:0]        cdata_wr,
    output logic               crd,
    output logic [11:0]        caddr_rd,
    input  logic [19:0]        cdata_rd,
    output logic [2:0]         csel
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Handshake: a requester holds req/we/sel/addr/wdata stable until it sees gnt high at a
    // rising edge; the transfer completes at that edge, and a still-high req is a new request.

    logic          lock_vld;
    logic [IW-1:0] lock_id;
    logic          win_vld;
    logic [IW-1:0] win_id;
    logic [IW-1:0] cand;
    logic [2:0]    win_sel;
    logic          win_we;
    logic [11:0]   win_addr;
    logic [19:0]   win_wdata;
    logic          pv  [0:RD_LAT];
    logic [IW-1:0] pid [0:RD_LAT];
    logic          pipe_any;

`ifndef ARB_FIXED_PRIO_EN
    logic [IW-1:0] rr_ptr;
`endif

    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        if (lock_vld && req[lock_id]) begin
            win_vld = 1'b1;
            win_id  = lock_id;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
`ifdef ARB_FIXED_PRIO_EN
                cand = IW'(i);
`else
                cand = IW'((int'(rr_ptr) + i) % NREQ);
`endif
                if (!win_vld && req[cand]) begin
                    win_vld = 1'b1;
                    win_id  = cand;
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (win_vld) gnt[win_id] = 1'b1;
        win_sel   = sel[int'(win_id)*3 +: 3];
        win_we    = we[win_id];
        win_addr  = addr[int'(win_id)*12 +: 12];
        win_wdata = wdata[int'(win_id)*20 +: 20];
    end

    always_comb begin
        pipe_any = 1'b0;
        for (int k = 0; k <= RD_LAT; k++) pipe_any = pipe_any | pv[k];
        rvalid = '0;
        if (pv[RD_LAT]) rvalid[pid[RD_LAT]] = 1'b1;
    end

    assign rdata = cdata_rd;
    assign busy  = (|req) | pipe_any;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_vld <= 1'b0;
            lock_id  <= '0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr   <= '0;
`endif
        end else if (win_vld) begin
            lock_vld <= lock[win_id];
            lock_id  <= win_id;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr   <= (win_id == IW'(NREQ-1)) ? '0 : win_id + 1'b1;
`endif
        end else begin
            lock_vld <= 1'b0;
        end
    end

    // A grant with sel == 0 completes but leaves the bus idle and flags err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cwr      <= 1'b0;
            crd      <= 1'b0;
            csel     <= '0;
            caddr_wr <= '0;
            caddr_rd <= '0;
            cdata_wr <= '0;
            err      <= 1'b0;
        end else begin
            cwr  <= 1'b0;
            crd  <= 1'b0;
            csel <= '0;
            if (win_vld) begin
                if (win_sel == 3'd0) begin
                    err <= 1'b1;
                end else if (win_we) begin
                    cwr      <= 1'b1;
                    csel     <= win_sel;
                    caddr_wr <= win_addr;
                    cdata_wr <= win_wdata;
                end else begin
                    crd      <= 1'b1;
                    csel     <= win_sel;
                    caddr_rd <= win_addr;
                end
            end
        end
    end

    // Stage 0 lines up with the crd-high cycle; stage RD_LAT is the data-valid cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= RD_LAT; k++) begin
                pv[k]  <= 1'b0;
                pid[k] <= '0;
            end
        end else begin
            pv[0]  <= win_vld && !win_we && (win_sel != 3'd0);
            pid[0] <= win_id;
            for (int k = 1; k <= RD_LAT; k++) begin
                pv[k]  <= pv[k-1];
                pid[k] <= pid[k-1];
            end
        end
    end
endmodule
